// File: rtl/vga_rect_fill_if.sv
// Command and pixel-write bus of the rectangle fill engine.
// master: command source / write-port observer side; slave: the engine itself.
interface vga_rect_fill_if #(
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned COLOR_W = 2
);
    logic               cmd_valid_i;
    logic               cmd_ready_o;
    logic [ADDR_W-1:0]  cmd_x_i;
    logic [ADDR_W-1:0]  cmd_y_i;
    logic [ADDR_W-1:0]  cmd_w_i;
    logic [ADDR_W-1:0]  cmd_h_i;
    logic [COLOR_W-1:0] cmd_color_i;
    logic               cmd_outline_i;
    logic               stall_i;
    logic [ADDR_W-1:0]  addr_x_o;
    logic [ADDR_W-1:0]  addr_y_o;
    logic [COLOR_W-1:0] color_o;
    logic               we_o;
    logic               busy_o;
    logic               done_o;

    modport master (
        output cmd_valid_i, cmd_x_i, cmd_y_i, cmd_w_i, cmd_h_i, cmd_color_i, cmd_outline_i,
        output stall_i,
        input  cmd_ready_o, addr_x_o, addr_y_o, color_o, we_o, busy_o, done_o
    );

    modport slave (
        input  cmd_valid_i, cmd_x_i, cmd_y_i, cmd_w_i, cmd_h_i, cmd_color_i, cmd_outline_i,
        input  stall_i,
        output cmd_ready_o, addr_x_o, addr_y_o, color_o, we_o, busy_o, done_o
    );
endinterface

// File: rtl/vga_rect_fill.sv
// Rectangle fill engine: takes one rectangle command, clips it to the frame and emits one
// pixel write per unstalled cycle in raster order, then pulses done.
// Optional macro VGA_RECT_OUTLINE_EN: honour cmd_outline_i and write only border pixels.
module vga_rect_fill #(
    parameter int unsigned H_MAX   = 1280,
    parameter int unsigned V_MAX   = 1024,
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned COLOR_W = 2
) (
    input logic            clk_i,
    input logic            rst_i,
    vga_rect_fill_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

    localparam logic [ADDR_W:0]   HMax   = (ADDR_W+1)'(H_MAX);
    localparam logic [ADDR_W:0]   VMax   = (ADDR_W+1)'(V_MAX);
    localparam logic [ADDR_W-1:0] HMaxM1 = ADDR_W'(H_MAX - 1);
    localparam logic [ADDR_W-1:0] VMaxM1 = ADDR_W'(V_MAX - 1);
    localparam logic [ADDR_W-1:0] One    = ADDR_W'(1);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pos_x_q, pos_y_q;
    logic [ADDR_W-1:0]  x0_q, x_end_q, y_end_q;
    logic [COLOR_W-1:0] color_q;

    logic [ADDR_W:0]    sum_x, sum_y;
    logic [ADDR_W-1:0]  x_end_d, y_end_d;
    logic               empty_cmd;
    logic               last_px;
    logic [ADDR_W-1:0]  step_x, step_y;

`ifdef VGA_RECT_OUTLINE_EN
    logic               outline_q;
    logic               right_ok_q;
    logic [ADDR_W-1:0]  y0_q;
    logic               interior_row;
`else
    logic               unused_outline;
    assign unused_outline = bus.cmd_outline_i;
`endif

    // Clipped end coordinates; sums are one bit wider so x+w never wraps.
    always_comb begin
        sum_x     = {1'b0, bus.cmd_x_i} + {1'b0, bus.cmd_w_i};
        sum_y     = {1'b0, bus.cmd_y_i} + {1'b0, bus.cmd_h_i};
        x_end_d   = (sum_x > HMax) ? HMaxM1 : (bus.cmd_x_i + bus.cmd_w_i - One);
        y_end_d   = (sum_y > VMax) ? VMaxM1 : (bus.cmd_y_i + bus.cmd_h_i - One);
        empty_cmd = (bus.cmd_w_i == '0) || (bus.cmd_h_i == '0) ||
                    ({1'b0, bus.cmd_x_i} >= HMax) || ({1'b0, bus.cmd_y_i} >= VMax);
    end

    // Raster step: next position after writing the current one.
    always_comb begin
        last_px = (pos_x_q == x_end_q) && (pos_y_q == y_end_q);
        step_x  = pos_x_q + One;
        step_y  = pos_y_q;
`ifdef VGA_RECT_OUTLINE_EN
        interior_row = (pos_y_q != y0_q) && (pos_y_q != y_end_q);
`endif
        if (pos_x_q == x_end_q) begin
            step_x = x0_q;
            step_y = pos_y_q + One;
`ifdef VGA_RECT_OUTLINE_EN
        end else if (outline_q && interior_row && (pos_x_q == x0_q)) begin
            // Skip the row interior; the right edge exists only if it was not clipped.
            if (right_ok_q) begin
                step_x = x_end_q;
            end else begin
                step_x = x0_q;
                step_y = pos_y_q + One;
            end
`endif
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid_i) begin
                    state_d = empty_cmd ? StDone : StFill;
                end
            end
            StFill: begin
                if (!bus.stall_i && last_px) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Control outputs decoded from the state; a stall gates the write strobe directly.
    always_comb begin
        bus.cmd_ready_o = 1'b0;
        bus.busy_o      = 1'b0;
        bus.done_o      = 1'b0;
        bus.we_o        = 1'b0;
        unique case (state_q)
            StIdle: bus.cmd_ready_o = 1'b1;
            StFill: begin
                bus.busy_o = 1'b1;
                bus.we_o   = !bus.stall_i;
            end
            StDone:  bus.done_o = 1'b1;
            default: bus.cmd_ready_o = 1'b0;
        endcase
    end

    // Command latch and position counters; empty commands leave the write bus untouched.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pos_x_q    <= '0;
            pos_y_q    <= '0;
            x0_q       <= '0;
            x_end_q    <= '0;
            y_end_q    <= '0;
            color_q    <= '0;
`ifdef VGA_RECT_OUTLINE_EN
            outline_q  <= 1'b0;
            right_ok_q <= 1'b0;
            y0_q       <= '0;
`endif
        end else if (state_q == StIdle && bus.cmd_valid_i && !empty_cmd) begin
            pos_x_q    <= bus.cmd_x_i;
            pos_y_q    <= bus.cmd_y_i;
            x0_q       <= bus.cmd_x_i;
            x_end_q    <= x_end_d;
            y_end_q    <= y_end_d;
            color_q    <= bus.cmd_color_i;
`ifdef VGA_RECT_OUTLINE_EN
            outline_q  <= bus.cmd_outline_i;
            right_ok_q <= (sum_x <= HMax);
            y0_q       <= bus.cmd_y_i;
`endif
        end else if (state_q == StFill && !bus.stall_i && !last_px) begin
            pos_x_q <= step_x;
            pos_y_q <= step_y;
        end
    end

    assign bus.addr_x_o = pos_x_q;
    assign bus.addr_y_o = pos_y_q;
    assign bus.color_o  = color_q;
endmodule

// File: tb/tb_vga_rect_fill.sv
// Bench for vga_rect_fill: a pixel-list model checked every cycle plus literal expectations.
module tb_vga_rect_fill;
    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic [1:0]  c;
    } px_t;

    logic clk;
    logic rst;
    vga_rect_fill_if #(.ADDR_W(11), .COLOR_W(2)) bus ();

    vga_rect_fill #(
        .H_MAX(1280), .V_MAX(1024), .ADDR_W(11), .COLOR_W(2)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int  vectors;
    int  miscompares;
    int  cyc;
    int  ph;           // model phase: 0 idle, 1 filling, 2 done pulse
    bit  check_en;
    px_t exp_q[$];     // pixels the model still expects, in raster order
    px_t act[$];       // every write seen on the bus
    int  act_cyc[$];
    int  done_cyc[$];
    int  acc_cyc;

    task automatic chk(input string nm, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Expected write list of a command, straight from the clipping/border rules.
    task automatic build(input int x, input int y, input int w, input int h, input int c,
                         input bit o);
        int  xe, ye;
        bit  keep;
        px_t p;
        if (w == 0 || h == 0 || x >= 1280 || y >= 1024) return;
        xe = ((x + w < 1280) ? x + w : 1280) - 1;
        ye = ((y + h < 1024) ? y + h : 1024) - 1;
        for (int yy = y; yy <= ye; yy++) begin
            for (int xx = x; xx <= xe; xx++) begin
                keep = 1'b1;
`ifdef VGA_RECT_OUTLINE_EN
                if (o) keep = (yy == y) || (yy == ye) || (xx == x) || (xx == x + w - 1);
`else
                if (o) keep = 1'b1;
`endif
                if (keep) begin
                    p.x = 11'(xx);
                    p.y = 11'(yy);
                    p.c = 2'(c);
                    exp_q.push_back(p);
                end
            end
        end
    endtask

    task automatic send(input int x, input int y, input int w, input int h, input int c,
                        input bit o);
        bit ok;
        @(posedge clk);
        #1;
        bus.cmd_x_i       = 11'(x);
        bus.cmd_y_i       = 11'(y);
        bus.cmd_w_i       = 11'(w);
        bus.cmd_h_i       = 11'(h);
        bus.cmd_color_i   = 2'(c);
        bus.cmd_outline_i = o;
        bus.cmd_valid_i   = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = bus.cmd_ready_o;
        end
        chk("accept_timeout", int'(ok), 1);
        @(posedge clk);
        #1;
        bus.cmd_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            ok = bus.cmd_ready_o;
        end
        chk("ready_return", int'(ok), 1);
    endtask

    task automatic chk_px(input string nm, input int idx, input int x, input int y,
                          input int c);
        if (idx < act.size()) begin
            chk({nm, "_x"}, int'(act[idx].x), x);
            chk({nm, "_y"}, int'(act[idx].y), y);
            chk({nm, "_c"}, int'(act[idx].c), c);
        end else begin
            chk({nm, "_present"}, act.size(), idx + 1);
        end
    endtask

    int       base;
    int       dbase;
    int       t1x[6] = '{10, 11, 12, 10, 11, 12};
    int       t1y[6] = '{20, 20, 20, 21, 21, 21};
    logic [11:0] pat = 12'b1011_0011_1010;

    initial begin
        vectors = 0; miscompares = 0; cyc = 0; ph = 0; check_en = 1'b0; acc_cyc = 0;
        rst = 1'b1;
        bus.cmd_valid_i = 1'b0; bus.cmd_x_i = '0; bus.cmd_y_i = '0; bus.cmd_w_i = '0;
        bus.cmd_h_i = '0; bus.cmd_color_i = '0; bus.cmd_outline_i = 1'b0; bus.stall_i = 1'b0;

        fork
            // Model update on each active edge, from the inputs as sampled there.
            forever begin
                @(posedge clk);
                cyc++;
                if (rst) begin
                    ph = 0;
                    exp_q.delete();
                end else begin
                    case (ph)
                        0: if (bus.cmd_valid_i) begin
                            build(int'(bus.cmd_x_i), int'(bus.cmd_y_i), int'(bus.cmd_w_i),
                                  int'(bus.cmd_h_i), int'(bus.cmd_color_i),
                                  bus.cmd_outline_i);
                            ph = (exp_q.size() == 0) ? 2 : 1;
                        end
                        1: if (!bus.stall_i) begin
                            void'(exp_q.pop_front());
                            if (exp_q.size() == 0) ph = 2;
                        end
                        default: ph = 0;
                    endcase
                end
            end
            // Compare DUT outputs with the model mid-cycle, and log the bus activity.
            forever begin
                @(negedge clk);
                if (check_en) begin
                    chk("cmd_ready", int'(bus.cmd_ready_o), int'(ph == 0));
                    chk("busy", int'(bus.busy_o), int'(ph == 1));
                    chk("done", int'(bus.done_o), int'(ph == 2));
                    chk("we", int'(bus.we_o), int'(ph == 1 && !bus.stall_i));
                    if (ph == 1 && !bus.stall_i && exp_q.size() > 0) begin
                        chk("addr_x", int'(bus.addr_x_o), int'(exp_q[0].x));
                        chk("addr_y", int'(bus.addr_y_o), int'(exp_q[0].y));
                        chk("color", int'(bus.color_o), int'(exp_q[0].c));
                    end
                    if (bus.we_o) begin
                        act.push_back({bus.addr_x_o, bus.addr_y_o, bus.color_o});
                        act_cyc.push_back(cyc);
                    end
                    if (bus.done_o) done_cyc.push_back(cyc);
                    if (bus.cmd_valid_i && bus.cmd_ready_o) acc_cyc = cyc;
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_en = 1'b1;

        // Reset state.
        @(negedge clk);
        chk("rst_ready", int'(bus.cmd_ready_o), 1);
        chk("rst_we", int'(bus.we_o), 0);
        chk("rst_addr_x", int'(bus.addr_x_o), 0);
        chk("rst_color", int'(bus.color_o), 0);

        // 3x2 fill at (10,20), blue.
        base = act.size(); dbase = done_cyc.size();
        send(10, 20, 3, 2, 2, 1'b0);
        wait_idle();
        chk("t1_writes", act.size() - base, 6);
        for (int i = 0; i < 6; i++) chk_px("t1_px", base + i, t1x[i], t1y[i], 2);
        if (act_cyc.size() > base) chk("t1_latency", act_cyc[base] - acc_cyc, 1);
        chk("t1_done_n", done_cyc.size() - dbase, 1);
        if (done_cyc.size() > dbase) chk("t1_done_at", done_cyc[dbase] - acc_cyc, 7);

        // Clipped at the bottom-right corner.
        base = act.size(); dbase = done_cyc.size();
        send(1278, 1023, 5, 4, 1, 1'b0);
        wait_idle();
        chk("t2_writes", act.size() - base, 2);
        chk_px("t2_p0", base, 1278, 1023, 1);
        chk_px("t2_p1", base + 1, 1279, 1023, 1);
        if (done_cyc.size() > dbase) chk("t2_done_at", done_cyc[dbase] - acc_cyc, 3);

        // Empty commands go straight to the done pulse.
        base = act.size(); dbase = done_cyc.size();
        send(5, 5, 0, 3, 3, 1'b0);
        wait_idle();
        chk("t3a_writes", act.size() - base, 0);
        if (done_cyc.size() > dbase) chk("t3a_done_at", done_cyc[dbase] - acc_cyc, 1);
        else chk("t3a_done_n", done_cyc.size() - dbase, 1);
        base = act.size(); dbase = done_cyc.size();
        send(1300, 5, 4, 3, 3, 1'b0);
        wait_idle();
        chk("t3b_writes", act.size() - base, 0);
        chk("t3b_done_n", done_cyc.size() - dbase, 1);

        // 2x2 fill with a 3-cycle stall on the second fill cycle.
        base = act.size(); dbase = done_cyc.size();
        send(10, 5, 2, 2, 3, 1'b0);
        @(posedge clk);
        #1;
        bus.stall_i = 1'b1;
        @(negedge clk);
        chk("t4_stall_we", int'(bus.we_o), 0);
        chk("t4_hold_x", int'(bus.addr_x_o), 11);
        chk("t4_hold_y", int'(bus.addr_y_o), 5);
        repeat (3) @(posedge clk);
        #1;
        bus.stall_i = 1'b0;
        wait_idle();
        chk("t4_writes", act.size() - base, 4);
        if (done_cyc.size() > dbase) chk("t4_done_at", done_cyc[dbase] - acc_cyc, 8);

        // Reset during the fifth write of a 10x10 fill.
        base = act.size(); dbase = done_cyc.size();
        send(100, 100, 10, 10, 1, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("t5_writes", act.size() - base, 5);
        chk("t5_no_done", done_cyc.size() - dbase, 0);
        chk("t5_ready", int'(bus.cmd_ready_o), 1);

        // Outline request: border only with the feature, solid fill without it.
        base = act.size();
        send(0, 0, 4, 4, 3, 1'b1);
        wait_idle();
`ifdef VGA_RECT_OUTLINE_EN
        chk("t6_writes", act.size() - base, 12);
        chk_px("t6_r1a", base + 4, 0, 1, 3);
        chk_px("t6_r1b", base + 5, 3, 1, 3);
`else
        chk("t6_writes", act.size() - base, 16);
`endif

        // Further corner cases checked through the model.
        send(1279, 0, 1, 1, 2, 1'b0);
        wait_idle();
        send(3, 1020, 2, 10, 1, 1'b0);
        wait_idle();
        send(1277, 2, 6, 4, 2, 1'b1);
        wait_idle();
        send(7, 9, 1, 5, 1, 1'b1);
        wait_idle();
        send(200, 300, 5, 3, 1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            bus.stall_i = pat[i];
        end
        bus.stall_i = 1'b0;
        wait_idle();

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
